// File: rtl/ahb_slave_port_mux.sv
// Per-slave AHB port multiplexer: steers the granted master's address phase to the
// slave, tracks the data-phase owner for write data and responses, and checks the
// two-cycle ERROR response sequence.
module ahb_slave_port_mux #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                               hclk,
    input  logic                               hreset_n,
    input  logic [MASTER_NUM-1:0]              hgrant_i,
    input  logic                               hsel_i,
    input  logic [MASTER_NUM-1:0][ADDR_W-1:0]  m_haddr,
    input  logic [MASTER_NUM-1:0][1:0]         m_htrans,
    input  logic [MASTER_NUM-1:0]              m_hwrite,
    input  logic [MASTER_NUM-1:0][2:0]         m_hsize,
    input  logic [MASTER_NUM-1:0][2:0]         m_hburst,
    input  logic [MASTER_NUM-1:0][DATA_W-1:0]  m_hwdata,
    output logic [ADDR_W-1:0]                  s_haddr,
    output logic [1:0]                         s_htrans,
    output logic                               s_hwrite,
    output logic [2:0]                         s_hsize,
    output logic [2:0]                         s_hburst,
    output logic                               s_hsel,
    output logic [DATA_W-1:0]                  s_hwdata,
    input  logic                               s_hreadyout,
    input  logic                               s_hresp,
    input  logic [DATA_W-1:0]                  s_hrdata,
    output logic [MASTER_NUM-1:0]              m_hready,
    output logic [MASTER_NUM-1:0]              m_hresp,
    output logic [DATA_W-1:0]                  m_hrdata,
    output logic [2:0]                         arb_hburst,
    output logic                               arb_hwait,
    output logic                               prot_err
);

    typedef enum logic [0:0] {StOkay, StErr1} resp_state_e;

    logic [MASTER_NUM-1:0] grant_oh;
    logic [MASTER_NUM-1:0] addr_owner;
    logic [MASTER_NUM-1:0] addr_owner_q;
    logic [MASTER_NUM-1:0] data_owner_q;
    logic                  data_valid_q;
    resp_state_e           resp_state_q, resp_state_d;

    // Address owner: lowest set grant bit wins; hold last owner while the grant is masked.
    // Reset also forces it to zero so the combinational outputs drop immediately.
    always_comb begin
        grant_oh   = hgrant_i & (~hgrant_i + MASTER_NUM'(1));
        addr_owner = '0;
        if (hreset_n) begin
            addr_owner = (hgrant_i != '0) ? grant_oh : addr_owner_q;
        end
    end

    // Address-phase AND-OR mux, zero latency.
    always_comb begin
        s_haddr  = '0;
        s_htrans = 2'b00;
        s_hwrite = 1'b0;
        s_hsize  = 3'b000;
        s_hburst = 3'b000;
        if (hsel_i) begin
            for (int unsigned i = 0; i < MASTER_NUM; i++) begin
                s_haddr  = s_haddr  | (m_haddr[i]  & {ADDR_W{addr_owner[i]}});
                s_htrans = s_htrans | (m_htrans[i] & {2{addr_owner[i]}});
                s_hwrite = s_hwrite | (m_hwrite[i] & addr_owner[i]);
                s_hsize  = s_hsize  | (m_hsize[i]  & {3{addr_owner[i]}});
                s_hburst = s_hburst | (m_hburst[i] & {3{addr_owner[i]}});
            end
        end
        s_hsel     = hsel_i & (addr_owner != '0);
        arb_hburst = s_hburst;
        arb_hwait  = ~s_hreadyout;
    end

    // Address owner register, updated every cycle.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            addr_owner_q <= '0;
        end else begin
            addr_owner_q <= addr_owner;
        end
    end

    // Data-phase owner advances only when the slave accepts the current beat.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            data_owner_q <= '0;
            data_valid_q <= 1'b0;
        end else if (s_hreadyout) begin
            data_owner_q <= addr_owner;
            data_valid_q <= s_hsel & s_htrans[1];
        end
    end

    // Write data and response routing follow the data-phase owner, one cycle behind.
    always_comb begin
        s_hwdata = '0;
        m_hrdata = s_hrdata;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            s_hwdata    = s_hwdata | (m_hwdata[i] & {DATA_W{data_valid_q & data_owner_q[i]}});
            m_hready[i] = (data_valid_q & data_owner_q[i]) ? s_hreadyout : 1'b1;
            m_hresp[i]  = (data_valid_q & data_owner_q[i]) ? s_hresp : 1'b0;
        end
    end

    // Response FSM state register.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            resp_state_q <= StOkay;
        end else begin
            resp_state_q <= resp_state_d;
        end
    end

    // Response FSM next state: ERR1 marks the first (wait) cycle of an ERROR response.
    always_comb begin
        resp_state_d = resp_state_q;
        unique case (resp_state_q)
            StOkay: if (data_valid_q & s_hresp & ~s_hreadyout) resp_state_d = StErr1;
            StErr1: if (!(s_hresp & ~s_hreadyout)) resp_state_d = StOkay;
            default: resp_state_d = StOkay;
        endcase
    end

    // Response FSM output: flag ERROR without its first cycle, or an abandoned ERROR.
    always_comb begin
        prot_err = 1'b0;
        unique case (resp_state_q)
            StOkay:  prot_err = s_hresp & s_hreadyout;
            StErr1:  prot_err = ~s_hresp;
            default: prot_err = 1'b0;
        endcase
        if (!hreset_n) prot_err = 1'b0;
    end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Directed self-checking bench for ahb_slave_port_mux.
module tb_ahb_slave_port_mux;

    localparam int unsigned MN = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                   hclk;
    logic                   hreset_n;
    logic [MN-1:0]          hgrant_i;
    logic                   hsel_i;
    logic [MN-1:0][AW-1:0]  m_haddr;
    logic [MN-1:0][1:0]     m_htrans;
    logic [MN-1:0]          m_hwrite;
    logic [MN-1:0][2:0]     m_hsize;
    logic [MN-1:0][2:0]     m_hburst;
    logic [MN-1:0][DW-1:0]  m_hwdata;
    logic [AW-1:0]          s_haddr;
    logic [1:0]             s_htrans;
    logic                   s_hwrite;
    logic [2:0]             s_hsize;
    logic [2:0]             s_hburst;
    logic                   s_hsel;
    logic [DW-1:0]          s_hwdata;
    logic                   s_hreadyout;
    logic                   s_hresp;
    logic [DW-1:0]          s_hrdata;
    logic [MN-1:0]          m_hready;
    logic [MN-1:0]          m_hresp;
    logic [DW-1:0]          m_hrdata;
    logic [2:0]             arb_hburst;
    logic                   arb_hwait;
    logic                   prot_err;

    int checks;
    int failures;

    ahb_slave_port_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hgrant_i(hgrant_i), .hsel_i(hsel_i),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata), .s_haddr(s_haddr), .s_htrans(s_htrans),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hsel(s_hsel),
        .s_hwdata(s_hwdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
        .s_hrdata(s_hrdata), .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
        .arb_hburst(arb_hburst), .arb_hwait(arb_hwait), .prot_err(prot_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_idle();
        hgrant_i = '0; hsel_i = 1'b0; m_haddr = '0; m_htrans = '0; m_hwrite = '0;
        m_hsize = '0; m_hburst = '0; m_hwdata = '0;
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        drive_idle();
        #3;
        checks++; if (s_htrans !== 2'b00 || s_hsel !== 1'b0) begin failures++;
            $display("FAIL rst_addr: htrans=%0d hsel=%0b required 0 0", s_htrans, s_hsel); end
        checks++; if (m_hready !== 4'b1111 || m_hresp !== 4'b0000) begin failures++;
            $display("FAIL rst_resp: hready=%b hresp=%b required 1111 0000", m_hready, m_hresp); end
        checks++; if (s_hwdata !== '0 || s_haddr !== '0 || prot_err !== 1'b0) begin failures++;
            $display("FAIL rst_data: hwdata=%h haddr=%h perr=%b required 0", s_hwdata, s_haddr,
                     prot_err); end
        tick();
        hreset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        hgrant_i = 4'b0010; hsel_i = 1'b1;
        m_haddr[1] = 32'h1000_0040; m_htrans[1] = 2'd2; m_hwrite[1] = 1'b1; m_hsize[1] = 3'd2;
        #1;
        checks++; if (s_haddr !== 32'h1000_0040 || s_htrans !== 2'd2 || s_hsel !== 1'b1
                      || s_hwrite !== 1'b1 || s_hsize !== 3'd2) begin failures++;
            $display("FAIL wr_addr: haddr=%h htrans=%0d hsel=%b hwrite=%b required 10000040 2 1 1",
                     s_haddr, s_htrans, s_hsel, s_hwrite); end
        tick();
        hgrant_i = '0; hsel_i = 1'b0; m_htrans[1] = 2'd0; m_hwdata[1] = 32'hDEAD_BEEF;
        #1;
        checks++; if (s_hwdata !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL wr_data: hwdata=%h required deadbeef", s_hwdata); end
        checks++; if (m_hready !== 4'b1111 || s_hsel !== 1'b0) begin failures++;
            $display("FAIL wr_ready: hready=%b hsel=%b required 1111 0", m_hready, s_hsel); end
        tick();
        #1;
        checks++; if (s_hwdata !== '0) begin failures++;
            $display("FAIL wr_data_done: hwdata=%h required 0", s_hwdata); end
        drive_idle();
        tick();
    endtask

    task automatic test_wait_states();
        hgrant_i = 4'b0100; hsel_i = 1'b1;
        m_haddr[2] = 32'h0000_2000; m_htrans[2] = 2'd2; m_hwrite[2] = 1'b0;
        tick();
        hgrant_i = '0; m_htrans[2] = 2'd0; s_hreadyout = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (m_hready !== 4'b1011 || arb_hwait !== 1'b1) begin failures++;
                $display("FAIL wait_cycle%0d: hready=%b hwait=%b required 1011 1", c, m_hready,
                         arb_hwait); end
            tick();
        end
        s_hreadyout = 1'b1; s_hrdata = 32'h1234_5678;
        #1;
        checks++; if (m_hready !== 4'b1111 || arb_hwait !== 1'b0 || m_hrdata !== 32'h1234_5678)
            begin failures++;
            $display("FAIL wait_done: hready=%b hwait=%b hrdata=%h required 1111 0 12345678",
                     m_hready, arb_hwait, m_hrdata); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] beat_data [4];
        beat_data[0] = 32'hA000_0000; beat_data[1] = 32'hA000_0001;
        beat_data[2] = 32'hA000_0002; beat_data[3] = 32'hA000_0003;
        hgrant_i = 4'b0001; hsel_i = 1'b1;
        m_hwrite[0] = 1'b1; m_hburst[0] = 3'd3; m_hsize[0] = 3'd2;
        for (int b = 0; b < 4; b++) begin
            m_haddr[0]  = 32'h0000_0100 + 32'(4 * b);
            m_htrans[0] = (b == 0) ? 2'd2 : 2'd3;
            if (b > 0) m_hwdata[0] = beat_data[b-1];
            #1;
            checks++; if (arb_hburst !== 3'd3 || s_haddr !== 32'h0000_0100 + 32'(4 * b)) begin
                failures++;
                $display("FAIL burst_addr%0d: hburst=%0d haddr=%h required 3 %h", b, arb_hburst,
                         s_haddr, 32'h0000_0100 + 32'(4 * b)); end
            if (b > 0) begin
                checks++; if (s_hwdata !== beat_data[b-1]) begin failures++;
                    $display("FAIL burst_data%0d: hwdata=%h required %h", b, s_hwdata,
                             beat_data[b-1]); end
            end
            tick();
        end
        // Last M0 data beat overlaps the M3 address phase.
        hgrant_i = 4'b1000; m_htrans[0] = 2'd0; m_hwdata[0] = beat_data[3];
        m_haddr[3] = 32'h0000_0300; m_htrans[3] = 2'd2; m_hwrite[3] = 1'b1;
        #1;
        checks++; if (s_hwdata !== beat_data[3] || s_haddr !== 32'h0000_0300
                      || arb_hburst !== 3'd0) begin failures++;
            $display("FAIL handover: hwdata=%h haddr=%h hburst=%0d required a0000003 300 0",
                     s_hwdata, s_haddr, arb_hburst); end
        tick();
        m_htrans[3] = 2'd0; m_hwdata[3] = 32'hC3C3_C3C3;
        #1;
        checks++; if (s_hwdata !== 32'hC3C3_C3C3 || m_hready !== 4'b1111) begin failures++;
            $display("FAIL handover_m3: hwdata=%h hready=%b required c3c3c3c3 1111", s_hwdata,
                     m_hready); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_legal_error();
        hgrant_i = 4'b0010; hsel_i = 1'b1; m_haddr[1] = 32'h0000_0500; m_htrans[1] = 2'd2;
        m_hwrite[1] = 1'b1;
        tick();
        hgrant_i = '0; m_htrans[1] = 2'd0; s_hresp = 1'b1; s_hreadyout = 1'b0;
        #1;
        checks++; if (m_hresp !== 4'b0010 || m_hready !== 4'b1101 || prot_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cycle1: hresp=%b hready=%b perr=%b required 0010 1101 0",
                     m_hresp, m_hready, prot_err); end
        tick();
        s_hreadyout = 1'b1;
        #1;
        checks++; if (m_hresp !== 4'b0010 || m_hready !== 4'b1111 || prot_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cycle2: hresp=%b hready=%b perr=%b required 0010 1111 0",
                     m_hresp, m_hready, prot_err); end
        tick();
        s_hresp = 1'b0;
        #1;
        checks++; if (m_hresp !== 4'b0000 || prot_err !== 1'b0) begin failures++;
            $display("FAIL err_after: hresp=%b perr=%b required 0000 0", m_hresp, prot_err); end
        drive_idle();
        tick();
    endtask

    task automatic test_illegal_error();
        s_hresp = 1'b1; s_hreadyout = 1'b1;
        #1;
        checks++; if (prot_err !== 1'b1) begin failures++;
            $display("FAIL illegal_single: perr=%b required 1", prot_err); end
        tick();
        s_hresp = 1'b0;
        #1;
        checks++; if (prot_err !== 1'b0) begin failures++;
            $display("FAIL illegal_pulse_end: perr=%b required 0", prot_err); end
        // ERROR first cycle abandoned before its second cycle.
        hgrant_i = 4'b0010; hsel_i = 1'b1; m_htrans[1] = 2'd2;
        tick();
        hgrant_i = '0; m_htrans[1] = 2'd0; s_hresp = 1'b1; s_hreadyout = 1'b0;
        tick();
        s_hresp = 1'b0; s_hreadyout = 1'b1;
        #1;
        checks++; if (prot_err !== 1'b1) begin failures++;
            $display("FAIL illegal_abandon: perr=%b required 1", prot_err); end
        tick();
        #1;
        checks++; if (prot_err !== 1'b0) begin failures++;
            $display("FAIL illegal_abandon_end: perr=%b required 0", prot_err); end
        drive_idle();
        tick();
    endtask

    task automatic test_grant_corner();
        hgrant_i = 4'b0110; hsel_i = 1'b1;
        m_haddr[1] = 32'h0000_1111; m_htrans[1] = 2'd2;
        m_haddr[2] = 32'h0000_2222; m_htrans[2] = 2'd3;
        #1;
        checks++; if (s_haddr !== 32'h0000_1111 || s_htrans !== 2'd2) begin failures++;
            $display("FAIL multi_grant: haddr=%h htrans=%0d required 1111 2", s_haddr,
                     s_htrans); end
        hsel_i = 1'b0;
        #1;
        checks++; if (s_hsel !== 1'b0 || s_htrans !== 2'd0 || s_haddr !== '0) begin failures++;
            $display("FAIL hsel_low: hsel=%b htrans=%0d haddr=%h required 0 0 0", s_hsel,
                     s_htrans, s_haddr); end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        hgrant_i = 4'b0100; hsel_i = 1'b1; m_hburst[2] = 3'd3;
        m_haddr[2] = 32'h0000_4000; m_htrans[2] = 2'd2; m_hwrite[2] = 1'b1;
        tick();
        m_haddr[2] = 32'h0000_4004; m_htrans[2] = 2'd3; m_hwdata[2] = 32'h5555_5555;
        s_hreadyout = 1'b0;
        #1;
        hreset_n = 1'b0;
        #1;
        checks++; if (s_htrans !== 2'd0 || s_hsel !== 1'b0 || m_hready !== 4'b1111
                      || s_hwdata !== '0) begin failures++;
            $display("FAIL rst_mid: htrans=%0d hsel=%b hready=%b hwdata=%h required 0 0 1111 0",
                     s_htrans, s_hsel, m_hready, s_hwdata); end
        hgrant_i = '0; s_hreadyout = 1'b1;
        #1;
        hreset_n = 1'b1;
        #1;
        checks++; if (s_hsel !== 1'b0 || s_htrans !== 2'd0) begin failures++;
            $display("FAIL rst_release: hsel=%b htrans=%0d required 0 0", s_hsel, s_htrans); end
        tick();
        #1;
        checks++; if (s_hwdata !== '0 || m_hready !== 4'b1111 || s_hsel !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale: hwdata=%h hready=%b hsel=%b required 0 1111 0", s_hwdata,
                     m_hready, s_hsel); end
        drive_idle();
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_wait_states();
        test_back_to_back();
        test_legal_error();
        test_illegal_error();
        test_grant_corner();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
